aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher (decrypt) datapath that sits opposite the encrypt-side round logic and reuses the same round-key store.
- Consumes one 128-bit ciphertext block over a valid/ready handshake.
- Processes one round per clock and requests round keys by index from an external combinational key store, in descending order (NR down to 0).
- Returns the plaintext block over a valid/ready handshake.
- One block in flight at a time; no pipelining across blocks.

---
 rtl/aes_pkg.sv | 76 +++++++
 rtl/aes_inv_sbox.sv | 28 ++
 rtl/aes_inv_cipher_iter.sv | 114 +++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the inverse-cipher GF(2^8) helpers.
// Bytes are packed FIPS-197 column-major: byte 0 at [127:120], byte i at row i%4, column i/4.
package aes_pkg;

    localparam int NB        = 4;
    localparam int BLOCK_W   = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_LAST  = 2'd2,
        S_DONE  = 2'd3
    } inv_state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
                gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
                gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
                gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
    endfunction

    // Row r rotates right by r: output column c takes input column (c - r) mod 4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: combinational 256-entry lookup.
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index
// from an external combinational store in descending order.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a ciphertext; key NR applied on accept
//   S_ROUND | full inverse round using key r_rnd (NR-1 down to 1)
//   S_LAST  | final round without InvMixColumns, key 0
//   S_DONE  | plaintext held on o_out_data until the output handshake
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR     = NR_AES256,
    parameter int KIDX_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [BLOCK_W-1:0]   i_in_data,
    output logic [KIDX_W-1:0]    o_rk_idx,
    input  logic [BLOCK_W-1:0]   i_rk_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [BLOCK_W-1:0]   o_out_data
);

    localparam logic [KIDX_W-1:0] RND_MAX = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] RND_ONE = KIDX_W'(1);

    inv_state_t          r_state;
    inv_state_t          w_state_nxt;
    logic [BLOCK_W-1:0]  r_st;
    logic [BLOCK_W-1:0]  w_st_nxt;
    logic [KIDX_W-1:0]   r_rnd;
    logic [KIDX_W-1:0]   w_rnd_nxt;

    logic [BLOCK_W-1:0]  w_sr;
    logic [BLOCK_W-1:0]  w_sb;
    logic [BLOCK_W-1:0]  w_ark;
    logic [BLOCK_W-1:0]  w_mix;

    assign w_sr = inv_shift_rows(r_st);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .i_byte (w_sr[8*g +: 8]),
            .o_byte (w_sb[8*g +: 8])
        );
    end

    assign w_ark = w_sb ^ i_rk_data;

    for (genvar c = 0; c < NB; c++) begin : g_mix
        assign w_mix[32*c +: 32] = inv_mix_column(w_ark[32*c +: 32]);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_rnd_nxt   = r_rnd;
        o_rk_idx    = RND_MAX;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = !i_rst;
                if (i_in_valid) begin
                    w_st_nxt    = i_in_data ^ i_rk_data;
                    w_rnd_nxt   = RND_MAX - RND_ONE;
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                o_rk_idx  = r_rnd;
                w_st_nxt  = w_mix;
                w_rnd_nxt = r_rnd - RND_ONE;
                if (r_rnd == RND_ONE) begin
                    w_state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                o_rk_idx    = '0;
                w_st_nxt    = w_ark;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_out_valid = 1'b1;
                o_out_data  = r_st;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_rnd_nxt   = RND_MAX;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_rnd   <= RND_MAX;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench: FIPS-197 vectors, handshake corner cases and random blocks
// against a byte-level AES reference whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    logic         clk;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, rk_data, out_data;
    logic [3:0]   rk_idx;
    logic         rst10, in_valid10, in_ready10, out_valid10, out_ready10;
    logic [127:0] in_data10, rk_data10, out_data10;
    logic [3:0]   rk_idx10;

    logic [127:0] rk14 [16];
    logic [127:0] rk10 [16];
    logic [31:0]  kw   [60];
    logic [7:0]   sbox_t     [256];
    logic [7:0]   inv_sbox_t [256];

    int n_pass  = 0;
    int n_total = 0;

    assign rk_data   = rk14[rk_idx];
    assign rk_data10 = rk10[rk_idx10];

    aes_inv_cipher_iter #(.NR(14), .KIDX_W(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .o_rk_idx(rk_idx), .i_rk_data(rk_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data)
    );

    aes_inv_cipher_iter #(.NR(10), .KIDX_W(4)) u_dut10 (
        .i_clk(clk), .i_rst(rst10), .i_in_valid(in_valid10), .o_in_ready(in_ready10),
        .i_in_data(in_data10), .o_rk_idx(rk_idx10), .i_rk_data(rk_data10),
        .o_out_valid(out_valid10), .i_out_ready(out_ready10), .o_out_data(out_data10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox;
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gm(inv, 8'(x));
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x]     = s;
            inv_sbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) kw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = kw[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            kw[i] = kw[i-nk] ^ tmp;
        end
    endtask

    task automatic load_key14(input logic [255:0] key);
        expand_key(key, 8, 14);
        for (int r = 0; r < 15; r++) rk14[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
        rk14[15] = '0;
    endtask

    task automatic load_key10(input logic [255:0] key);
        expand_key(key, 4, 10);
        for (int r = 0; r < 11; r++) rk10[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
        for (int r = 11; r < 16; r++) rk10[r] = '0;
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   m [4];
        logic [127:0] k, o;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        k = (nr == 14) ? rk14[nr] : rk10[nr];
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int rd = nr - 1; rd >= 0; rd--) begin
            k = (nr == 14) ? rk14[rd] : rk10[rd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*((c + r) % 4) + r] = s[4*c + r];
            for (int i = 0; i < 16; i++) s[i] = inv_sbox_t[t[i]] ^ k[127 - 8*i -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        t[4*c + r] = 8'h00;
                        for (int j = 0; j < 4; j++) t[4*c + r] = t[4*c + r] ^ gm(m[(j - r + 4) % 4], s[4*c + j]);
                    end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1; rst10 = 1'b1;
        tick; tick;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst got %b want 0", in_ready); else n_pass++;
        rst = 1'b0; rst10 = 1'b0;
        tick;
        n_total++; if (in_ready !== 1'b1 || rk_idx !== 4'd14) $display("FAIL reset_idle got in_ready=%b rk_idx=%0d want 1/14", in_ready, rk_idx); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || out_data !== 128'h0) $display("FAIL reset_out got valid=%b data=%h want 0/0", out_valid, out_data); else n_pass++;
        n_total++; if (in_ready10 !== 1'b1 || rk_idx10 !== 4'd10) $display("FAIL reset_idle10 got in_ready=%b rk_idx=%0d want 1/10", in_ready10, rk_idx10); else n_pass++;
    endtask

    task automatic test_kat256;
        load_key14(C3_KEY);
        in_data = C3_CT; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1 || rk_idx !== 4'd14) $display("FAIL kat256_accept got in_ready=%b rk_idx=%0d want 1/14", in_ready, rk_idx); else n_pass++;
        tick;
        in_valid = 1'b0; in_data = rand128();
        for (int j = 13; j >= 0; j--) begin
            n_total++;
            if (rk_idx !== 4'(j) || out_valid !== 1'b0)
                $display("FAIL kat256_rk_seq got rk_idx=%0d valid=%b want %0d/0", rk_idx, out_valid, j);
            else n_pass++;
            tick;
        end
        n_total++; if (out_valid !== 1'b1 || out_data !== KAT_PT) $display("FAIL kat256_data got valid=%b data=%h want 1/%h", out_valid, out_data, KAT_PT); else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL kat256_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [127:0] ct2, exp2;
        int lat;
        ct2 = rand128();
        exp2 = ref_decrypt(ct2, 14);
        in_data = C3_CT; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick;
        in_data = ct2;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin tick; lat++; end
        n_total++; if (lat !== 14) $display("FAIL bp_latency got %0d want 14", lat); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_data !== KAT_PT || in_ready !== 1'b0)
                $display("FAIL bp_hold got valid=%b in_ready=%b data=%h want 1/0/%h", out_valid, in_ready, out_data, KAT_PT);
            else n_pass++;
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_after_handshake got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_total++; if (in_ready !== 1'b0 || rk_idx !== 4'd13) $display("FAIL bp_second_accept got in_ready=%b rk_idx=%0d want 0/13", in_ready, rk_idx); else n_pass++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin tick; lat++; end
        n_total++; if (lat !== 14 || out_data !== exp2) $display("FAIL bp_second_data got lat=%0d data=%h want 14/%h", lat, out_data, exp2); else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [127:0] ct [2];
        logic [127:0] exp [2];
        int acc_cyc [2];
        int n_acc, n_out, cyc;
        logic acc;
        load_key14({rand128(), rand128()});
        for (int i = 0; i < 2; i++) begin ct[i] = rand128(); exp[i] = ref_decrypt(ct[i], 14); end
        n_acc = 0; n_out = 0; cyc = 0;
        in_data = ct[0]; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        while (n_out < 2 && cyc < 80) begin
            if (out_valid === 1'b1) begin
                n_total++;
                if (out_data !== exp[n_out]) $display("FAIL b2b_data%0d got %h want %h", n_out, out_data, exp[n_out]); else n_pass++;
                n_out++;
            end
            acc = in_valid && in_ready;
            if (acc) acc_cyc[n_acc] = cyc;
            tick;
            cyc++;
            if (acc) begin
                n_acc++;
                if (n_acc < 2) in_data = ct[n_acc]; else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        n_total++; if (n_out !== 2 || n_acc !== 2) $display("FAIL b2b_count got acc=%0d out=%0d want 2/2", n_acc, n_out); else n_pass++;
        // NR cycles to DONE, one for the output handshake, one in IDLE for the next accept
        n_total++; if (n_acc == 2 && acc_cyc[1] - acc_cyc[0] !== 16) $display("FAIL b2b_gap got %0d want 16", acc_cyc[1] - acc_cyc[0]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [127:0] ct2, exp2;
        int w;
        load_key14({rand128(), rand128()});
        in_data = rand128(); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        w = 0;
        while (rk_idx !== 4'd7 && w < 20) begin tick; w++; end
        n_total++; if (rk_idx !== 4'd7) $display("FAIL rmid_reach7 got rk_idx=%0d want 7", rk_idx); else n_pass++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || rk_idx !== 4'd14 || out_valid !== 1'b0)
            $display("FAIL rmid_idle got in_ready=%b rk_idx=%0d valid=%b want 1/14/0", in_ready, rk_idx, out_valid);
        else n_pass++;
        ct2 = rand128(); exp2 = ref_decrypt(ct2, 14);
        in_data = ct2; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 30) begin tick; w++; end
        n_total++; if (w !== 14 || out_data !== exp2) $display("FAIL rmid_after got lat=%0d data=%h want 14/%h", w, out_data, exp2); else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_kat128;
        int lat;
        load_key10(C1_KEY);
        in_data10 = C1_CT; in_valid10 = 1'b1; out_ready10 = 1'b0;
        #1;
        n_total++; if (in_ready10 !== 1'b1 || rk_idx10 !== 4'd10) $display("FAIL kat128_accept got in_ready=%b rk_idx=%0d want 1/10", in_ready10, rk_idx10); else n_pass++;
        tick;
        in_valid10 = 1'b0;
        lat = 0;
        while (out_valid10 !== 1'b1 && lat < 30) begin tick; lat++; end
        n_total++; if (lat !== 10 || out_data10 !== KAT_PT) $display("FAIL kat128_data got lat=%0d data=%h want 10/%h", lat, out_data10, KAT_PT); else n_pass++;
        out_ready10 = 1'b1;
        tick;
        out_ready10 = 1'b0;
        n_total++; if (out_valid10 !== 1'b0) $display("FAIL kat128_release got valid=%b want 0", out_valid10); else n_pass++;
    endtask

    task automatic test_random;
        logic [127:0] ct, exp;
        int w, cyc, got, n_out;
        n_out = 0;
        for (int b = 0; b < 1000; b++) begin
            load_key14({rand128(), rand128()});
            ct = rand128(); exp = ref_decrypt(ct, 14);
            in_valid = 1'b0; out_ready = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick;
            in_data = ct; in_valid = 1'b1;
            w = 0;
            while (in_ready !== 1'b1 && w < 5) begin tick; w++; end
            if (w == 5) begin n_total++; $display("FAIL rand_accept_timeout block %0d in_ready=%b want 1", b, in_ready); end
            tick;
            got = 0; cyc = 0;
            while (got == 0 && cyc < 80) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = rand128();
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    n_total++;
                    if (out_data !== exp) $display("FAIL rand_data block %0d got %h want %h", b, out_data, exp); else n_pass++;
                    got = 1; n_out++;
                end
                tick;
                cyc++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            #1;
            if (got == 0) begin n_total++; $display("FAIL rand_out_timeout block %0d valid=%b want 1", b, out_valid); end
            n_total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rand_no_dup block %0d got valid=%b in_ready=%b want 0/1", b, out_valid, in_ready);
            else n_pass++;
        end
        n_total++; if (n_out !== 1000) $display("FAIL rand_block_count got %0d want 1000", n_out); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        rst10 = 1'b1; in_valid10 = 1'b0; out_ready10 = 1'b0; in_data10 = '0;
        for (int r = 0; r < 16; r++) begin rk14[r] = '0; rk10[r] = '0; end
        build_sbox;
        test_reset;
        test_kat256;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_kat128;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
